// File: rtl/seq_divider_pkg.sv
// Shared ALU definitions for the iterative divider: op encodings, FSM states
// and the XLEN-wide boundary constants.
package seq_divider_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_e;

   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;

   function automatic logic is_signed_op(input logic [1:0] control);
      return ~control[0];
   endfunction

   function automatic logic is_rem_op(input logic [1:0] control);
      return control[1];
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between an ALU issue stage (master) and the divider (slave).
interface seq_divider_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [1:0]       control;
   logic             busy;
   logic             out_valid;
   logic [WIDTH-1:0] out;

   modport master (
      output start, in1, in2, control,
      input  busy, out_valid, out
   );

   modport slave (
      input  start, in1, in2, control,
      output busy, out_valid, out
   );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module seq_divider_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0]   rem,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // rem is always below the divisor, so the extra top bit is zero and the
   // sign of diff is a clean borrow indicator.
   assign shifted  = {rem, dividend_bit};
   assign diff     = shifted - {2'b00, divisor};
   assign q_bit    = ~diff[WIDTH+1];
   assign rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit: one quotient bit per cycle,
// divide-by-zero and signed overflow resolved in a single cycle.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_divider_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(INT_MIN >> (XLEN - WIDTH));
   localparam logic [WIDTH-1:0] ONES_W = WIDTH'(ALL_ONES);

   state_e           state, state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   rem;
   logic             take_rem;
   logic             negate;
   logic [WIDTH-1:0] result;
   logic             out_valid_q;

   logic             accept;
   logic             sgn, neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             div_zero, ovf, special;
   logic [WIDTH-1:0] special_val;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic [WIDTH-1:0] sel_val, fix_val;

   // Operand decode, only meaningful on the accepting edge.
   always_comb begin
      sgn         = is_signed_op(bus.control);
      neg_a       = sgn & bus.in1[WIDTH-1];
      neg_b       = sgn & bus.in2[WIDTH-1];
      mag_a       = neg_a ? -bus.in1 : bus.in1;
      mag_b       = neg_b ? -bus.in2 : bus.in2;
      div_zero    = (bus.in2 == '0);
      ovf         = sgn && (bus.in1 == MIN_W) && (bus.in2 == ONES_W);
      special     = div_zero | ovf;
      special_val = '0;
      if (div_zero)
         special_val = is_rem_op(bus.control) ? bus.in1 : ONES_W;
      else
         special_val = is_rem_op(bus.control) ? '0 : MIN_W;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = special ? FIX : CALC;
            end
         end
         CALC:    if (count == CNT_W'(WIDTH-1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   seq_divider_step #(.WIDTH(WIDTH)) u_step (
      .rem          (rem),
      .dividend_bit (quo[WIDTH-1]),
      .divisor      (divisor),
      .rem_next     (rem_next),
      .q_bit        (q_bit)
   );

   assign sel_val = take_rem ? rem[WIDTH-1:0] : quo;
   assign fix_val = negate ? -sel_val : sel_val;

   // quo starts as the dividend magnitude and fills with quotient bits from
   // the right as the dividend bits leave on the left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         quo         <= '0;
         divisor     <= '0;
         rem         <= '0;
         take_rem    <= 1'b0;
         negate      <= 1'b0;
         result      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_next;
         out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  count    <= '0;
                  rem      <= '0;
                  divisor  <= mag_b;
                  // Special results ride through FIX as a plain quotient.
                  quo      <= special ? special_val : mag_a;
                  take_rem <= special ? 1'b0 : is_rem_op(bus.control);
                  negate   <= special ? 1'b0 :
                              (is_rem_op(bus.control) ? neg_a : (neg_a ^ neg_b));
               end
            end
            CALC: begin
               rem   <= rem_next;
               quo   <= {quo[WIDTH-2:0], q_bit};
               count <= count + 1'b1;
            end
            FIX: begin
               result      <= fix_val;
               out_valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out       = result;
endmodule

// File: tb/tb_seq_divider.sv
// Directed table plus randomized checks of seq_divider against an arithmetic
// reference of the RISC-V divide/remainder rules.
module tb_seq_divider;
   import seq_divider_pkg::*;

   localparam int W = 64;
   localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;
   localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   ctrl;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_result(input logic [1:0] ctrl,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      if (b == '0) return ctrl[1] ? a : ONES;
      if (!ctrl[0] && a == MINV && b == ONES) return ctrl[1] ? '0 : MINV;
      if (!ctrl[0]) begin
         if (ctrl[1]) r = $signed(a) % $signed(b);
         else         r = $signed(a) / $signed(b);
      end else begin
         r = ctrl[1] ? (a % b) : (a / b);
      end
      return r;
   endfunction

   function automatic int ref_latency(input logic [1:0] ctrl,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0 || (!ctrl[0] && a == MINV && b == ONES)) return 1;
      return W + 1;
   endfunction

   // Issue one op; inject_at>0 pulses a second start on that cycle of the op.
   task automatic run_op(input logic [1:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inject_at, output logic [W-1:0] res, output int lat,
                         output logic busy_ok, output logic [W-1:0] out_e0);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.control = ctrl;
      bus.in1     = a;
      bus.in2     = b;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.in1     = {$urandom, $urandom};
      bus.in2     = {$urandom, $urandom};
      bus.control = 2'($urandom);
      busy_ok     = bus.busy;
      out_e0      = bus.out;
      lat         = -1;
      res         = 'x;
      for (int n = 1; n <= 200; n++) begin
         if (n == inject_at) begin
            bus.start = 1'b1;
            bus.in1   = 64'd9;
            bus.in2   = 64'd1;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.out_valid) begin
            lat = n;
            res = bus.out;
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
   endtask

   vec_t tbl [18];

   initial begin
      logic [W-1:0] res, out_e0, prev;
      logic [W-1:0] a, b;
      logic [1:0]   ctrl;
      logic         busy_ok, seen_valid;
      int           lat, mode;

      bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.control = 2'b00;

      tbl[0]  = '{DIV,  64'd10, 64'd2, 64'd5, 65};
      tbl[1]  = '{DIV,  64'd11, 64'd3, 64'd3, 65};
      tbl[2]  = '{DIV,  64'd10, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFB, 65};
      tbl[3]  = '{REM,  64'hFFFF_FFFF_FFFF_FFF5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
      tbl[4]  = '{REM,  64'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 65};
      tbl[5]  = '{DIV,  MINV, 64'hFFFF_FFFF_FFFF_FFFE, 64'h4000_0000_0000_0000, 65};
      tbl[6]  = '{DIV,  64'hFFFF_FFFF_FFFF_FFF6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFB, 65};
      tbl[7]  = '{DIVU, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65};
      tbl[8]  = '{REMU, ONES, 64'd16, 64'hF, 65};
      tbl[9]  = '{DIVU, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd1, 65};
      tbl[10] = '{REMU, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 65};
      tbl[11] = '{DIV,  64'd100, 64'd0, ONES, 1};
      tbl[12] = '{REM,  64'd100, 64'd0, 64'h64, 1};
      tbl[13] = '{DIV,  MINV, ONES, MINV, 1};
      tbl[14] = '{REM,  MINV, ONES, 64'd0, 1};
      tbl[15] = '{DIVU, 64'd5, 64'd0, ONES, 1};
      tbl[16] = '{REMU, 64'd7, 64'd0, 64'd7, 1};
      tbl[17] = '{DIVU, MINV, ONES, 64'd0, 65};

      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {63'd0, bus.busy}, '0);
      check("reset out_valid", {63'd0, bus.out_valid}, '0);
      check("reset out", bus.out, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Consecutive calls start in each out_valid cycle, so this also covers back-to-back issue.
      for (int i = 0; i < 18; i++) begin
         run_op(tbl[i].ctrl, tbl[i].a, tbl[i].b, 0, res, lat, busy_ok, out_e0);
         check($sformatf("vec%0d result", i), res, tbl[i].exp);
         check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
         check($sformatf("vec%0d busy", i), {63'd0, busy_ok}, 64'd1);
      end

      // start while busy must be dropped
      run_op(DIV, 64'd100, 64'd7, 10, res, lat, busy_ok, out_e0);
      check("ignore-start result", res, 64'd14);
      check("ignore-start latency", 64'(lat), 64'd65);

      // single-cycle strobe, held result, and result not cleared by a new start
      @(posedge clk); #1;
      check("valid pulse width", {63'd0, bus.out_valid}, '0);
      repeat (3) @(posedge clk);
      #1;
      check("out held", bus.out, 64'd14);
      run_op(DIVU, 64'd50, 64'd5, 0, res, lat, busy_ok, out_e0);
      check("out kept at accept", out_e0, 64'd14);
      check("after-hold result", res, 64'd10);

      // reset in the middle of CALC
      @(negedge clk);
      bus.start = 1'b1; bus.control = DIV; bus.in1 = 64'd1000; bus.in2 = 64'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort busy", {63'd0, bus.busy}, '0);
      check("abort out", bus.out, '0);
      check("abort out_valid", {63'd0, bus.out_valid}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int n = 0; n < 80; n++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen_valid = 1'b1;
      end
      check("abort no valid", {63'd0, seen_valid}, '0);

      // randomized ops against the reference
      prev = '0;
      for (int k = 0; k < 40; k++) begin
         ctrl = 2'($urandom_range(0, 3));
         mode = $urandom_range(0, 9);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case (mode)
            0: b = '0;
            1: begin a = MINV; b = ONES; end
            2: b = 64'($urandom_range(1, 15));
            3: a = 64'($urandom_range(0, 1000));
            4: b = 64'($urandom_range(1, 15)) | ONES << 8;
            default: ;
         endcase
         run_op(ctrl, a, b, 0, res, lat, busy_ok, out_e0);
         check($sformatf("rnd%0d ctrl=%0d a=%h b=%h result", k, ctrl, a, b), res, ref_result(ctrl, a, b));
         check($sformatf("rnd%0d latency", k), 64'(lat), 64'(ref_latency(ctrl, a, b)));
         check($sformatf("rnd%0d out at accept", k), out_e0, prev);
         prev = res;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 integer divide/remainder unit for the 64-bit ALU. It implements the RISC-V DIV, DIVU, REM and REMU operations.
- Operands are taken with a start pulse. The result is returned after a fixed latency, marked by a one-cycle out_valid strobe.
- Divide-by-zero and signed overflow follow RISC-V semantics and finish early.

Parameters:
- WIDTH, 64, operand and result width in bits. The iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only while busy=0.
- in1  in  WIDTH  dividend.
- in2  in  WIDTH  divisor.
- control  in  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- busy  out  1  high from the accepting edge until out_valid is asserted.
- out_valid  out  1  one-cycle pulse marking out as valid.
- out  out  WIDTH  result; held stable from out_valid until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, out_valid=0, out=0, counter=0, internal registers=0. Asserting reset mid-operation aborts the operation; no out_valid is produced for it.
- States:
  - IDLE: wait for start.
  - CALC: iteration in progress.
  - FIX: sign fixup and result register.
  - IDLE is re-entered after FIX.
- Accept: on the edge where state=IDLE and start=1 (edge E0):
  - latch control, the dividend/divisor magnitudes and the result sign; busy goes to 1.
  - signed ops (00, 10) take the two's-complement magnitude of negative operands; unsigned ops use the raw values.
- Special cases, decided at E0. At E1, out is loaded, out_valid=1, busy=0, state=IDLE.
  - in2==0: quotient = all ones (0xFFFF_FFFF_FFFF_FFFF) for DIV and DIVU; remainder = in1 for REM and REMU.
  - Signed overflow (control[0]=0, in1=0x8000_0000_0000_0000, in2=all ones): DIV result = 0x8000_0000_0000_0000; REM result = 0.
- Normal path:
  - restoring division, one quotient bit per edge, MSB first, over edges E1..E64 in CALC.
  - partial remainder register is WIDTH+1 bits.
  - FIX at E65: apply sign, load out, out_valid=1, busy=0.
  - total latency 65 cycles from the accepting edge.
- Sign rules (signed ops): quotient truncates toward zero and is negated iff the operand signs differ. The remainder takes the sign of the dividend.
  - Examples: -11 REM 3 = -2; 11 REM -3 = 2; -10 DIV 2 = -5.
- Unsigned ops (01, 11) use no sign handling. Example: 0xFFFF_FFFF_FFFF_FFFF DIVU 2 = 0x7FFF_FFFF_FFFF_FFFF.
- start while busy=1 is ignored; no queuing.
- out_valid is a single-cycle pulse. out retains its value until the next completion; it is never cleared by a new start.
- Inputs need to be valid only at the accepting edge; changes afterwards have no effect.
- Simultaneous out_valid and start: in the out_valid cycle the state is IDLE, so a start is accepted (back-to-back operation).

Decomposition:
- Shared ALU package holds:
  - control encodings DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11;
  - the FSM state enum (IDLE, CALC, FIX);
  - constants INT_MIN and ALL_ONES for WIDTH.
- One natural sub-module, seq_divider_step: a combinational single restoring step taking the partial remainder, next dividend bit and divisor, and producing the new remainder and quotient bit.

Test Plan:
- DIV 10/2 and 11/3 -> out=5 and 3; out_valid 65 cycles after start, busy high in between.
- Signed mixed signs: DIV 10/-2 -> 0xFFFF_FFFF_FFFF_FFFB; REM -11/3 -> 0xFFFF_FFFF_FFFF_FFFE; REM 11/-3 -> 2; DIV 0x8000_0000_0000_0000/-2 -> 0x4000_0000_0000_0000.
- Unsigned: DIVU 0xFFFF_FFFF_FFFF_FFFF/2 -> 0x7FFF_FFFF_FFFF_FFFF; REMU 0xFFFF_FFFF_FFFF_FFFF%16 -> 0xF; DIVU and REMU of 0x123456789ABCDEF0 by itself -> 1 and 0.
- Divide by zero: DIV 100/0 -> all ones; REM 100/0 -> 0x64; each result valid at E1.
- Overflow: DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0; each valid at E1.
- Control: start while busy is ignored (result matches the first operation); rst_n low mid-CALC -> busy=0, out=0, no out_valid; back-to-back start in the out_valid cycle is accepted.
